int_prio_arbiter: RTL and testbench

//  Priority arbiter/sequencer for the CPU interrupt path. Edge-latches up to 8 sources,

---
 rtl/int_prio_arbiter_pkg.sv | 21 ++
 rtl/int_prio_arbiter_if.sv | 19 +
 rtl/int_prio_arbiter_select.sv | 30 +++
 rtl/int_prio_arbiter.sv | 162 ++++++++++++++++
 tb/tb_int_prio_arbiter.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/int_prio_arbiter_pkg.sv
// Shared types and constants for the interrupt priority arbiter.
package int_arb_pkg;

    localparam int NSRC_MAX   = 8;
    localparam int PRIO_W_DEF = 2;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        SERVICE
    } arb_state_e;

    localparam logic [2:0] REG_PEND     = 3'd0;
    localparam logic [2:0] REG_IE       = 3'd1;
    localparam logic [2:0] REG_PRIO_LO  = 3'd2;
    localparam logic [2:0] REG_PRIO_HI  = 3'd3;
    localparam logic [2:0] REG_CLAIM    = 3'd4;
    localparam logic [2:0] REG_COMPLETE = 3'd5;
    localparam logic [2:0] REG_LAT      = 3'd6;

endpackage

// File: rtl/int_prio_arbiter_if.sv
// Wishbone-style register port of the interrupt arbiter.
interface int_prio_arbiter_if;
    logic       i_wb_cyc;
    logic [2:0] i_wb_adr;
    logic       i_wb_we;
    logic [7:0] i_wb_data;
    logic [7:0] o_wb_rdt;
    logic       o_wb_ack;

    modport master (
        output i_wb_cyc, i_wb_adr, i_wb_we, i_wb_data,
        input  o_wb_rdt, o_wb_ack
    );

    modport slave (
        input  i_wb_cyc, i_wb_adr, i_wb_we, i_wb_data,
        output o_wb_rdt, o_wb_ack
    );
endinterface

// File: rtl/int_prio_arbiter_select.sv
// Combinational winner pick: highest priority among candidates, ties go to the lowest index.
module int_prio_select
    import int_arb_pkg::*;
#(
    parameter int NSRC   = NSRC_MAX,
    parameter int PRIO_W = PRIO_W_DEF
) (
    input  logic [NSRC-1:0]        cand,
    input  logic [NSRC*PRIO_W-1:0] prio,
    output logic [2:0]             win_id,
    output logic                   win_valid
);

    logic [PRIO_W-1:0] best;

    // Ascending scan with strict compare keeps the lowest index on a tie.
    always_comb begin
        win_valid = 1'b0;
        win_id    = '0;
        best      = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (cand[i] && (!win_valid || prio[i*PRIO_W +: PRIO_W] > best)) begin
                win_valid = 1'b1;
                win_id    = 3'(i);
                best      = prio[i*PRIO_W +: PRIO_W];
            end
        end
    end

endmodule

// File: rtl/int_prio_arbiter.sv
// Interrupt priority arbiter: edge-latched sources, IE mask, claim/complete sequencing.
// Optional REQ-latency counter enabled by defining INTARB_LATENCY_EN.
//   state   | meaning
//   IDLE    | no request presented
//   REQ     | irq high, irq_id tracks current winner
//   SERVICE | claimed, irq_id frozen, waiting for COMPLETE
module int_prio_arbiter
    import int_arb_pkg::*;
#(
    parameter int NSRC = NSRC_MAX
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [NSRC-1:0]   src,
    output logic              irq,
    output logic [2:0]        irq_id,
    input  logic              ins_ack,
    int_prio_arbiter_if.slave wb
);

    // Register layout packs four 2-bit priority fields per byte.
    localparam logic [15:0] PRIO_MASK = 16'((32'd1 << (PRIO_W_DEF*NSRC)) - 32'd1);

    logic [NSRC-1:0] prev_q, pend_q, pend_d, ie_q, prio_nz, cand, edge_det;
    logic [15:0]     prio_q;
    arb_state_e      state_q, state_d;
    logic            irq_d, claim, complete, wr, win_valid;
    logic [2:0]      irq_id_d, win_id;
    logic [7:0]      lat_rd;

    assign wr       = wb.i_wb_cyc & wb.i_wb_we & wb.o_wb_ack;
    assign complete = wr && (wb.i_wb_adr == REG_COMPLETE);
    assign edge_det = src & ~prev_q;

    always_comb begin
        prio_nz = '0;
        for (int i = 0; i < NSRC; i++)
            prio_nz[i] = |prio_q[PRIO_W_DEF*i +: PRIO_W_DEF];
    end

    assign cand = pend_q & ie_q & prio_nz;

    int_prio_select #(.NSRC(NSRC), .PRIO_W(PRIO_W_DEF)) u_sel (
        .cand      (cand),
        .prio      (prio_q[PRIO_W_DEF*NSRC-1:0]),
        .win_id    (win_id),
        .win_valid (win_valid)
    );

    // Clears first, then new edges OR in so a coincident edge always survives.
    always_comb begin
        pend_d = pend_q;
        if (wr && (wb.i_wb_adr == REG_PEND))
            pend_d = pend_d & ~wb.i_wb_data[NSRC-1:0];
        for (int i = 0; i < NSRC; i++)
            if (claim && (irq_id == 3'(i)))
                pend_d[i] = 1'b0;
        pend_d = pend_d | edge_det;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            prev_q      <= '0;
            pend_q      <= '0;
            ie_q        <= '0;
            prio_q      <= '0;
            wb.o_wb_ack <= 1'b0;
        end else begin
            prev_q      <= src;
            pend_q      <= pend_d;
            wb.o_wb_ack <= wb.i_wb_cyc & ~wb.o_wb_ack;
            if (wr && (wb.i_wb_adr == REG_IE))
                ie_q <= wb.i_wb_data[NSRC-1:0];
            if (wr && (wb.i_wb_adr == REG_PRIO_LO))
                prio_q[7:0] <= wb.i_wb_data & PRIO_MASK[7:0];
            if (wr && (wb.i_wb_adr == REG_PRIO_HI))
                prio_q[15:8] <= wb.i_wb_data & PRIO_MASK[15:8];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            irq     <= 1'b0;
            irq_id  <= '0;
        end else begin
            state_q <= state_d;
            irq     <= irq_d;
            irq_id  <= irq_id_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        irq_d    = irq;
        irq_id_d = irq_id;
        claim    = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_valid) begin
                    state_d  = REQ;
                    irq_d    = 1'b1;
                    irq_id_d = win_id;
                end
            end
            REQ: begin
                if (ins_ack) begin
                    state_d = SERVICE;
                    irq_d   = 1'b0;
                    claim   = 1'b1;
                end else if (!win_valid) begin
                    state_d = IDLE;
                    irq_d   = 1'b0;
                end else begin
                    irq_id_d = win_id;
                end
            end
            SERVICE: begin
                if (complete)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef INTARB_LATENCY_EN
    logic [7:0] lat_cnt_q, lat_q;

    // Counter holds (cycles in REQ - 1); the claim cycle itself is added on latch.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lat_cnt_q <= '0;
            lat_q     <= '0;
        end else begin
            if (state_q != REQ)
                lat_cnt_q <= '0;
            else if (lat_cnt_q != 8'hFF)
                lat_cnt_q <= lat_cnt_q + 8'd1;
            if (claim)
                lat_q <= (lat_cnt_q == 8'hFF) ? 8'hFF : lat_cnt_q + 8'd1;
        end
    end

    assign lat_rd = lat_q;
`else
    assign lat_rd = 8'h00;
`endif

    always_comb begin
        wb.o_wb_rdt = '0;
        case (wb.i_wb_adr)
            REG_PEND:    wb.o_wb_rdt = 8'(pend_q);
            REG_IE:      wb.o_wb_rdt = 8'(ie_q);
            REG_PRIO_LO: wb.o_wb_rdt = prio_q[7:0];
            REG_PRIO_HI: wb.o_wb_rdt = prio_q[15:8];
            REG_CLAIM:   wb.o_wb_rdt = {(state_q == SERVICE), 4'b0000, irq_id};
            REG_LAT:     wb.o_wb_rdt = lat_rd;
            default:     wb.o_wb_rdt = '0;
        endcase
    end

endmodule

// File: tb/tb_int_prio_arbiter.sv
// Directed self-checking bench for int_prio_arbiter.
module tb_int_prio_arbiter;

    logic       clk = 1'b0;
    logic       rstn;
    logic [7:0] src;
    logic       irq;
    logic [2:0] irq_id;
    logic       ins_ack;
    logic [7:0] rdv;
    int         total = 0;
    int         bad = 0;

    int_prio_arbiter_if wb_if ();

    int_prio_arbiter #(.NSRC(8)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .src     (src),
        .irq     (irq),
        .irq_id  (irq_id),
        .ins_ack (ins_ack),
        .wb      (wb_if)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
        end
    endtask

    task automatic chk_irq(input string tag, input logic exp_irq, input logic [2:0] exp_id);
        chk({tag, "_irq"}, {7'b0, irq}, {7'b0, exp_irq});
        chk({tag, "_id"}, {5'b0, irq_id}, {5'b0, exp_id});
    endtask

    task automatic chk_reg(input string tag, input logic [2:0] a, input logic [7:0] exp);
        wb_if.i_wb_adr = a;
        #1;
        rdv = wb_if.o_wb_rdt;
        chk(tag, rdv, exp);
    endtask

    task automatic wb_write(input logic [2:0] a, input logic [7:0] d);
        wb_if.i_wb_cyc  = 1'b1;
        wb_if.i_wb_we   = 1'b1;
        wb_if.i_wb_adr  = a;
        wb_if.i_wb_data = d;
        tick();
        chk("wb_ack_pulse", {7'b0, wb_if.o_wb_ack}, 8'h01);
        tick();
        chk("wb_ack_drop", {7'b0, wb_if.o_wb_ack}, 8'h00);
        wb_if.i_wb_cyc = 1'b0;
        wb_if.i_wb_we  = 1'b0;
    endtask

    task automatic claim_pulse();
        ins_ack = 1'b1;
        tick();
        ins_ack = 1'b0;
    endtask

    initial begin
        rstn            = 1'b0;
        src             = 8'h00;
        ins_ack         = 1'b0;
        wb_if.i_wb_cyc  = 1'b0;
        wb_if.i_wb_we   = 1'b0;
        wb_if.i_wb_adr  = 3'd0;
        wb_if.i_wb_data = 8'h00;
        tick();
        tick();

        // reset state
        chk_irq("rst", 1'b0, 3'd0);
        chk("rst_ack", {7'b0, wb_if.o_wb_ack}, 8'h00);
        chk_reg("rst_pend", 3'd0, 8'h00);
        chk_reg("rst_ie", 3'd1, 8'h00);
        chk_reg("rst_claim", 3'd4, 8'h00);
        rstn = 1'b1;
        tick();

        // 1: single source, latency and claim
        wb_write(3'd1, 8'hFF);
        wb_write(3'd2, 8'h80);
        chk_reg("t1_ie", 3'd1, 8'hFF);
        chk_reg("t1_prio", 3'd2, 8'h80);
        src = 8'h08;
        tick();
        chk_reg("t1_pend", 3'd0, 8'h08);
        chk_irq("t1_early", 1'b0, 3'd0);
        tick();
        chk_irq("t1_raise", 1'b1, 3'd3);
        chk_reg("t1_claim_req", 3'd4, 8'h03);
        claim_pulse();
        chk_irq("t1_svc", 1'b0, 3'd3);
        chk_reg("t1_pend_clr", 3'd0, 8'h00);
        chk_reg("t1_claim_svc", 3'd4, 8'h83);
        wb_write(3'd5, 8'h00);
        tick();
        chk_irq("t1_done", 1'b0, 3'd3);
        src = 8'h00;
        tick();

        // 2: different priorities, service order
        wb_write(3'd2, 8'h04);
        wb_write(3'd3, 8'h30);
        src = 8'h42;
        tick();
        chk_reg("t2_pend", 3'd0, 8'h42);
        tick();
        chk_irq("t2_raise", 1'b1, 3'd6);
        claim_pulse();
        chk_reg("t2_pend_ack", 3'd0, 8'h02);
        wb_write(3'd5, 8'h00);
        chk_irq("t2_idle", 1'b0, 3'd6);
        tick();
        chk_irq("t2_reraise", 1'b1, 3'd1);
        claim_pulse();
        wb_write(3'd5, 8'h00);
        src = 8'h00;
        tick();

        // 3: tie to lowest index, preemption in REQ, W1C drops request
        wb_write(3'd2, 8'h20);
        wb_write(3'd3, 8'hC8);
        src = 8'h24;
        tick();
        tick();
        chk_irq("t3_tie", 1'b1, 3'd2);
        src = 8'hA4;
        tick();
        chk_irq("t3_pre", 1'b1, 3'd2);
        tick();
        chk_irq("t3_replace", 1'b1, 3'd7);
        claim_pulse();
        chk_reg("t3_pend_ack", 3'd0, 8'h24);
        wb_write(3'd5, 8'h00);
        tick();
        chk_irq("t3_next", 1'b1, 3'd2);
        wb_write(3'd0, 8'h24);
        chk_reg("t3_w1c", 3'd0, 8'h00);
        tick();
        chk_irq("t3_drop", 1'b0, 3'd2);
        src = 8'h00;
        tick();

        // 4: no nesting while in SERVICE
        wb_write(3'd2, 8'h21);
        src = 8'h04;
        tick();
        tick();
        chk_irq("t4_raise", 1'b1, 3'd2);
        claim_pulse();
        src = 8'h05;
        tick();
        tick();
        chk_irq("t4_hold", 1'b0, 3'd2);
        chk_reg("t4_pend", 3'd0, 8'h01);
        claim_pulse();
        chk_reg("t4_ack_ignored", 3'd0, 8'h01);
        chk_reg("t4_still_svc", 3'd4, 8'h82);
        wb_write(3'd5, 8'h00);
        chk_irq("t4_idle", 1'b0, 3'd2);
        tick();
        chk_irq("t4_reraise", 1'b1, 3'd0);
        claim_pulse();
        wb_write(3'd5, 8'h00);
        src = 8'h00;
        tick();

        // 5: edge wins over coincident W1C; IE cleared during REQ
        wb_write(3'd1, 8'h00);
        src = 8'h04;
        tick();
        src = 8'h00;
        tick();
        chk_reg("t5_pend_pre", 3'd0, 8'h04);
        wb_if.i_wb_cyc  = 1'b1;
        wb_if.i_wb_we   = 1'b1;
        wb_if.i_wb_adr  = 3'd0;
        wb_if.i_wb_data = 8'h04;
        tick();
        src = 8'h04;
        tick();
        wb_if.i_wb_cyc = 1'b0;
        wb_if.i_wb_we  = 1'b0;
        chk_reg("t5_set_wins", 3'd0, 8'h04);
        wb_write(3'd1, 8'hFF);
        tick();
        chk_irq("t5_raise", 1'b1, 3'd2);
        wb_write(3'd1, 8'h00);
        chk_irq("t5_mask_lag", 1'b1, 3'd2);
        tick();
        chk_irq("t5_masked", 1'b0, 3'd2);
        wb_write(3'd0, 8'h04);
        chk_reg("t5_w1c", 3'd0, 8'h00);
        src = 8'h00;
        tick();
        chk_reg("t5_reg7", 3'd7, 8'h00);
`ifndef INTARB_LATENCY_EN
        wb_write(3'd6, 8'hAA);
        chk_reg("t5_lat_wr_ignored", 3'd6, 8'h00);
`endif

        // 6: REQ latency, then reset in SERVICE
        wb_write(3'd1, 8'hFF);
        src = 8'h04;
        tick();
        tick();
        chk_irq("t6_raise", 1'b1, 3'd2);
        repeat (4) tick();
        claim_pulse();
        chk_reg("t6_claim", 3'd4, 8'h82);
`ifdef INTARB_LATENCY_EN
        chk_reg("t6_lat", 3'd6, 8'h05);
`else
        chk_reg("t6_lat", 3'd6, 8'h00);
`endif
        rstn = 1'b0;
        #1;
        chk_irq("t6_rst", 1'b0, 3'd0);
        chk_reg("t6_rst_pend", 3'd0, 8'h00);
        chk_reg("t6_rst_ie", 3'd1, 8'h00);
        chk_reg("t6_rst_prio", 3'd2, 8'h00);
        chk_reg("t6_rst_claim", 3'd4, 8'h00);
        chk_reg("t6_rst_lat", 3'd6, 8'h00);
        src = 8'h00;
        tick();
        rstn = 1'b1;
        tick();
        tick();
        chk_irq("t6_after", 1'b0, 3'd0);
        chk_reg("t6_after_pend", 3'd0, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
